// File: rtl/multdiv_pkg.sv
// Shared constants for the multiply/divide sequencer.
// State codes, iteration defaults and the exception code.
package multdiv_pkg;

   localparam int ITER_W     = 5;
   localparam int MULT_ITERS = 16;
   localparam int DIV_ITERS  = 32;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_INIT = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_FIN  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic DIV_ZERO = 1'b1;

endpackage

// File: rtl/iter_counter.sv
// Iteration up-counter read by the multiply/divide datapath.
// Reset and clear both zero it; enable advances it by one.
module iter_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/multdiv_sequencer.sv
// Control FSM for the iterative multiply/divide datapath.
// Moore outputs: everything is decoded from registered state.
module multdiv_sequencer #(
   parameter int ITER_W     = multdiv_pkg::ITER_W,
   parameter int MULT_ITERS = multdiv_pkg::MULT_ITERS,
   parameter int DIV_ITERS  = multdiv_pkg::DIV_ITERS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ctrl_mult,
   input  logic              ctrl_div,
   input  logic              divisor_zero,
   output logic              busy,
   output logic              init,
   output logic              step,
   output logic [ITER_W-1:0] iter_count,
   output logic              op_is_div,
   output logic              finish,
   output logic              data_ready,
   output logic              data_exception
);

   import multdiv_pkg::*;

   logic [2:0]      state;
   logic [2:0]      nxt;
   logic            op_div;
   logic            exc;
   logic            start;
   logic            last;
   logic            cnt_clr;
   logic            cnt_en;
   logic [ITER_W:0] last_val;

   assign start = ctrl_mult | ctrl_div;

   // One extra bit so N = 2^ITER_W still fits as N-1 = all-ones.
   assign last_val = op_div ? (ITER_W+1)'(DIV_ITERS - 1)
                            : (ITER_W+1)'(MULT_ITERS - 1);
   assign last     = ({1'b0, iter_count} == last_val);

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE: nxt = start ? S_INIT : S_IDLE;
         S_INIT: begin
            if (start)
               nxt = S_INIT;
            else if (op_div && divisor_zero)
               nxt = S_DONE;
            else
               nxt = S_RUN;
         end
         S_RUN: begin
            if (start)
               nxt = S_INIT;
            else if (last)
               nxt = S_FIN;
            else
               nxt = S_RUN;
         end
         S_FIN:  nxt = start ? S_INIT : S_DONE;
         S_DONE: nxt = start ? S_INIT : S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= S_IDLE;
         op_div <= 1'b0;
         exc    <= 1'b0;
      end else begin
         state <= nxt;
         if (start)
            op_div <= ctrl_div & ~ctrl_mult;
         exc <= (state == S_INIT && op_div && divisor_zero && !start)
                ? DIV_ZERO : 1'b0;
      end
   end

   // Zero the counter on any restart and whenever we are not stepping.
   assign cnt_clr = start | (state != S_RUN);
   assign cnt_en  = step & ~last;

   iter_counter #(
      .W(ITER_W)
   ) u_cnt (
      .clk  (clk),
      .reset(reset),
      .clear(cnt_clr),
      .en   (cnt_en),
      .count(iter_count)
   );

   assign init           = (state == S_INIT);
   assign step           = (state == S_RUN);
   assign finish         = (state == S_FIN);
   assign busy           = init | step | finish;
   assign data_ready     = (state == S_DONE);
   assign data_exception = data_ready & exc;
   assign op_is_div      = op_div;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: directed scenarios then random
// traffic, checked against a cycles-since-start reference model.
module tb_multdiv_sequencer;

   localparam int W  = 5;
   localparam int NM = 16;
   localparam int ND = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         ctrl_mult;
   logic         ctrl_div;
   logic         divisor_zero;
   logic         busy;
   logic         init;
   logic         step;
   logic [W-1:0] iter_count;
   logic         op_is_div;
   logic         finish;
   logic         data_ready;
   logic         data_exception;

   int tests = 0;
   int fails = 0;

   // Reference model: age = cycles since the start pulse.
   bit m_act  = 0;
   int m_age  = 0;
   bit m_div  = 0;
   bit m_zero = 0;

   always #5 clk = ~clk;

   multdiv_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .ctrl_mult     (ctrl_mult),
      .ctrl_div      (ctrl_div),
      .divisor_zero  (divisor_zero),
      .busy          (busy),
      .init          (init),
      .step          (step),
      .iter_count    (iter_count),
      .op_is_div     (op_is_div),
      .finish        (finish),
      .data_ready    (data_ready),
      .data_exception(data_exception)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d at t=%0t",
                tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit cm, input bit cd,
                             input bit dz);
      int n;
      n = m_div ? ND : NM;
      if (!r) begin
         m_act = 0; m_age = 0; m_div = 0; m_zero = 0;
      end else if (cm || cd) begin
         m_act = 1; m_age = 1; m_div = cd && !cm; m_zero = 0;
      end else if (m_act) begin
         if (m_zero || m_age == n + 3) begin
            m_act = 0; m_zero = 0; m_age = 0;
         end else if (m_age == 1 && m_div && dz) begin
            m_zero = 1; m_age = 2;
         end else begin
            m_age++;
         end
      end
   endtask

   task automatic check_all();
      int n, e_it;
      bit e_init, e_step, e_fin, e_rdy, e_exc;
      n      = m_div ? ND : NM;
      e_init = m_act && m_age == 1;
      e_step = m_act && !m_zero && m_age >= 2 && m_age <= n + 1;
      e_fin  = m_act && !m_zero && m_age == n + 2;
      e_rdy  = m_act && (m_zero ? m_age == 2 : m_age == n + 3);
      e_exc  = e_rdy && m_zero;
      e_it   = e_step ? m_age - 2 : (e_fin ? n - 1 : 0);
      chk("init", int'(init), int'(e_init));
      chk("step", int'(step), int'(e_step));
      chk("finish", int'(finish), int'(e_fin));
      chk("busy", int'(busy), int'(e_init | e_step | e_fin));
      chk("data_ready", int'(data_ready), int'(e_rdy));
      chk("data_exception", int'(data_exception), int'(e_exc));
      chk("iter_count", int'(iter_count), e_it);
      chk("op_is_div", int'(op_is_div), int'(m_div));
   endtask

   task automatic cyc(input bit r, input bit cm, input bit cd, input bit dz);
      reset        = r;
      ctrl_mult    = cm;
      ctrl_div     = cd;
      divisor_zero = dz;
      @(posedge clk);
      #1;
      model_edge(r, cm, cd, dz);
      check_all();
   endtask

   task automatic idle(input int k, input bit dz);
      for (int i = 0; i < k; i++) cyc(1, 0, 0, dz);
   endtask

   initial begin
      reset = 0; ctrl_mult = 0; ctrl_div = 0; divisor_zero = 0;
      cyc(0, 0, 0, 0);
      cyc(0, 1, 1, 1);
      idle(2, 0);

      // multiply, full length
      cyc(1, 1, 0, 1);
      idle(22, 1);
      // divide, no zero divisor, counter reaches all-ones
      cyc(1, 0, 1, 0);
      idle(38, 0);
      // divide by zero
      cyc(1, 0, 1, 1);
      idle(5, 1);
      // divide aborted by multiply at iter 8
      cyc(1, 0, 1, 0);
      idle(9, 0);
      cyc(1, 1, 0, 0);
      idle(30, 0);
      // simultaneous starts select multiply
      cyc(1, 1, 1, 0);
      idle(22, 0);
      // reset mid-run at iter 7
      cyc(1, 1, 0, 0);
      idle(8, 0);
      chk("iter_before_reset", int'(iter_count), 7);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      idle(25, 0);
      // start in DONE goes straight to INIT
      cyc(1, 1, 0, 0);
      idle(18, 0);
      cyc(1, 0, 1, 1);
      idle(3, 1);
      // held start restarts each cycle
      for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0);
      idle(40, 0);

      for (int i = 0; i < 4000; i++) begin
         bit r, cm, cd, dz;
         r  = ($urandom_range(0, 199) != 0);
         cm = ($urandom_range(0, 39) == 0);
         cd = ($urandom_range(0, 39) == 0);
         dz = ($urandom_range(0, 2) == 0);
         cyc(r, cm, cd, dz);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Multi-cycle control unit for the processor's iterative multiply/divide datapath.
- Accepts a single-cycle start pulse and sequences the datapath through operand load, a fixed number of iteration steps, and a final correction/latch cycle.
- Signals completion or divide-by-zero through a one-cycle ready pulse.
- Owns a 5-bit iteration counter that the datapath also reads, for shift amounts and quotient bit index.

Parameters:
- ITER_W, 5: iteration counter width.
- MULT_ITERS, 16: step cycles for a multiply (radix-4, 32-bit operands).
- DIV_ITERS, 32: step cycles for a divide (restoring, 32-bit operands).
- Constraint: MULT_ITERS and DIV_ITERS each lie in the range 1 to 2^ITER_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 = reset.
- ctrl_mult  in  1  start-multiply pulse.
- ctrl_div  in  1  start-divide pulse.
- divisor_zero  in  1  datapath flag; valid in the INIT cycle.
- busy  out  1  high from INIT through FIN.
- init  out  1  datapath loads operands; clears accumulator/remainder.
- step  out  1  datapath performs one iteration.
- iter_count  out  ITER_W  index of the current step; 0 during the first step.
- op_is_div  out  1  latched operation type; stable while busy.
- finish  out  1  datapath applies final correction and latches the result.
- data_ready  out  1  one-cycle completion pulse.
- data_exception  out  1  divide-by-zero; meaningful only when data_ready=1.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE, iter_count=0, op_is_div=0.
  - All outputs 0.
  - Reset overrides every other input, including mid-operation.
- Outputs are Moore: decoded from registered state; no combinational path from inputs to outputs.
- States: IDLE, INIT, RUN, FIN, DONE.
- IDLE:
  - Outputs low.
  - ctrl_mult=1 or ctrl_div=1 → INIT.
  - op_is_div is latched as ctrl_div & ~ctrl_mult, so simultaneous starts select multiply.
- INIT:
  - init=1, busy=1, iter_count forced to 0.
  - If op_is_div=1 and divisor_zero=1 → DONE with an exception flag set; otherwise → RUN.
- RUN:
  - step=1, busy=1.
  - Let N = DIV_ITERS if op_is_div, else MULT_ITERS.
  - If iter_count == N-1 → FIN with iter_count held; otherwise iter_count increments by 1.
  - The counter never wraps during a legal run. When N = 2^ITER_W, the last step occurs at all-ones.
- FIN: finish=1, busy=1 → DONE.
- DONE:
  - data_ready=1 for exactly one cycle.
  - data_exception=1 only if the exception flag is set.
  - busy=0; → IDLE. The exception flag clears on leaving DONE.
- Latency, with the ctrl pulse in cycle 0:
  - INIT in cycle 1.
  - RUN in cycles 2 to N+1.
  - FIN in cycle N+2.
  - data_ready in cycle N+3.
  - Divide-by-zero gives data_ready and data_exception in cycle 2, with no step or finish pulses.
- Start while busy (INIT/RUN/FIN):
  - Aborts the current operation and → INIT on the next edge.
  - The new op_is_div is latched and iter_count is cleared.
  - No data_ready is issued for the aborted operation.
- Start in DONE: data_ready still pulses that cycle, then the block goes to INIT (not IDLE).
- ctrl held high for multiple cycles: each high cycle counts as a start, so the operation restarts repeatedly. Callers must pulse.
- iter_count is 0 in IDLE, INIT and DONE.

Decomposition:
- Shared package `multdiv_pkg` holds:
  - the state encoding (3-bit, one named constant per state);
  - ITER_W, MULT_ITERS and DIV_ITERS defaults;
  - the DIV_ZERO exception code.
- One sub-module: `iter_counter`, an ITER_W-bit up-counter.
  - Synchronous active-low clear, a synchronous clear input, and an enable; counter value output.
  - Instantiated once; driven by the FSM with clear in INIT and enable = step & ~last_step.

Test Plan:
- Reset (reset=0) held 2 cycles during RUN at iter_count=7 → next cycle all outputs 0, state IDLE, iter_count=0; no data_ready ever issued.
- ctrl_mult pulse in cycle 0 → init in cycle 1; step in cycles 2–17 with iter_count 0..15; finish in cycle 18; data_ready=1 and data_exception=0 in cycle 19 only; busy high in cycles 1–18.
- ctrl_div pulse, divisor_zero=0 → step in 32 cycles (iter_count 0..31, no wrap), finish in cycle 34, data_ready in cycle 35, op_is_div=1 throughout.
- ctrl_div pulse with divisor_zero=1 in cycle 1 → no step/finish; data_ready=1 and data_exception=1 in cycle 2; busy=0 in cycle 2.
- ctrl_div in cycle 0, then ctrl_mult in cycle 10 (RUN, iter_count=8) → INIT in cycle 11, op_is_div=0, iter_count=0, data_ready in cycle 29 only; no pulse near cycle 35.
- ctrl_mult and ctrl_div both high in cycle 0 → multiply selected (op_is_div=0), 16 steps, data_ready in cycle 19.
